lif_update_scheduler: RTL



---
 rtl/lif_update_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lif_update_scheduler.sv
// Shared LIF update engine: round-robin arbitration over N_CH
// channels, 3-state CALC/WB sequencing, per-channel V and refractory state.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req[N_CH]    : level update request per channel
//   i_syn        : packed input currents, channel k at [k*W +: W]
//   gnt[N_CH]    : one-hot grant, high during the CALC cycle
//   spike[N_CH]  : one-hot spike pulse after writeback
//   v_valid      : pulse, v_ch/v_mem_out describe a finished update
//   v_ch         : channel of the finished update
//   v_mem_out    : computed potential (before spike reset)
//   busy         : FSM not in IDLE
module lif_update_scheduler #(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int RCW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] i_syn,
  output logic [N_CH-1:0]   gnt,
  output logic [N_CH-1:0]   spike,
  output logic              v_valid,
  output logic [CW-1:0]     v_ch,
  output logic [W-1:0]      v_mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WB
  } state_t;

  localparam logic [CW:0] NCH_W = (CW + 1)'(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t state;
  state_t state_nx;

  logic [N_CH-1:0][W-1:0]   v_mem;
  logic [N_CH-1:0][RCW-1:0] rc;

  logic [CW-1:0] ptr;
  logic [CW-1:0] ch_q;
  logic [W-1:0]  i_q;
  logic [W-1:0]  vn_q;

  logic [CW-1:0] pick;
  logic          pick_ok;
  logic [CW:0]   idx_w;

  logic [W-1:0]   leak;
  logic [W:0]     sum;
  logic [RCW-1:0] rc_cur;
  logic [W-1:0]   vn_calc;
  logic           fire;

  // Round-robin search starting at ptr (one past the last grant).
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx_w   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx_w = {1'b0, ptr} + (CW + 1)'(i);
      if (idx_w >= NCH_W) begin
        idx_w = idx_w - NCH_W;
      end
      if (!pick_ok && req[idx_w[CW-1:0]]) begin
        pick_ok = 1'b1;
        pick    = idx_w[CW-1:0];
      end
    end
  end

  // Leak, integrate and saturate; input is ignored while refractory.
  always_comb begin
    leak    = v_mem[ch_q] >> LEAK_SHIFT;
    sum     = {1'b0, leak} + {1'b0, i_q};
    rc_cur  = rc[ch_q];
    vn_calc = sum[W] ? {W{1'b1}} : sum[W-1:0];
    if (rc_cur != '0) begin
      vn_calc = leak;
    end
  end

  // Compare happens on the already saturated value.
  assign fire = (32'(vn_q) >= THRESH);

  always_comb begin
    state_nx = state;
    gnt      = '0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (pick_ok) begin
          state_nx = S_CALC;
        end
      end
      S_CALC: begin
        gnt[ch_q] = 1'b1;
        state_nx  = S_WB;
      end
      S_WB: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_mem     <= '0;
      rc        <= '0;
      ptr       <= '0;
      ch_q      <= '0;
      i_q       <= '0;
      vn_q      <= '0;
      spike     <= '0;
      v_valid   <= 1'b0;
      v_ch      <= '0;
      v_mem_out <= '0;
    end else begin
      spike   <= '0;
      v_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_ok) begin
            ch_q <= pick;
            i_q  <= i_syn[pick*W +: W];
            ptr  <= (pick == LAST_CH) ? '0 : pick + CW'(1);
          end
        end
        S_CALC: begin
          vn_q <= vn_calc;
          if (rc_cur != '0) begin
            rc[ch_q] <= rc_cur - RCW'(1);
          end
        end
        S_WB: begin
          if (fire) begin
            v_mem[ch_q] <= '0;
            rc[ch_q]    <= RCW'(REFRACT);
            spike[ch_q] <= 1'b1;
          end else begin
            v_mem[ch_q] <= vn_q;
          end
          v_valid   <= 1'b1;
          v_ch      <= ch_q;
          v_mem_out <= vn_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
